// File: rtl/stack_pkg.sv
// Shared definitions for the stack-machine operand stack.
//   stack_op_e : 3-bit operation code driven by the instruction decoder.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_REDUCE  = 3'd4,
        OP_DUP     = 3'd5,
        OP_SWAP    = 3'd6,
        OP_CLRERR  = 3'd7
    } stack_op_e;

endpackage

// File: rtl/stack_file_op_check.sv
// Combinational legality decode for one stack operation.
//   op      : operation code
//   count   : current number of valid entries
//   legal   : op may be applied (stack state changes only if 1)
//   set_ovf : op failed for lack of room
//   set_unf : op failed for lack of entries
//   delta   : signed count change when legal (-1, 0, +1)
module stack_op_check
    import stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  stack_op_e         op,
    input  logic [CW-1:0]     count,
    output logic              legal,
    output logic              set_ovf,
    output logic              set_unf,
    output logic signed [1:0] delta
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic is_empty;
    logic is_full;
    logic lt_two;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    assign lt_two   = (count < CW'(2));

    always_comb begin
        set_ovf = 1'b0;
        set_unf = 1'b0;
        delta   = 2'sd0;
        unique case (op)
            OP_PUSH: begin
                set_ovf = is_full;
                delta   = 2'sd1;
            end
            OP_POP: begin
                set_unf = is_empty;
                delta   = -2'sd1;
            end
            OP_REPLACE: set_unf = is_empty;
            OP_REDUCE: begin
                set_unf = lt_two;
                delta   = -2'sd1;
            end
            OP_DUP: begin
                // An empty stack has nothing to copy: underflow wins.
                set_unf = is_empty;
                set_ovf = is_full && !is_empty;
                delta   = 2'sd1;
            end
            OP_SWAP: set_unf = lt_two;
            default: ;
        endcase
        legal = !(set_ovf || set_unf);
        if (!legal) begin
            delta = 2'sd0;
        end
    end

endmodule

// File: rtl/stack_file.sv
// Parametrised LIFO operand stack between instruction decoder and ALU.
//   clock/reset : single clock, asynchronous active-high reset
//   op, wr_data : operation and data word (PUSH/REPLACE/REDUCE)
//   peek_idx    : depth below top for peek_data (0 = top)
//   tos, nos    : top and second entries, 0 when absent
//   count, empty, full : occupancy
//   overflow, underflow: sticky error flags, cleared by CLRERR or reset
module stack_file
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  stack_op_e        op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    peek_idx,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] peek_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic              legal;
    logic              set_ovf;
    logic              set_unf;
    logic signed [1:0] delta;

    logic [PW-1:0] top_idx;
    logic [PW-1:0] nos_idx;
    logic [PW-1:0] push_idx;
    logic [PW-1:0] peek_pos;

    stack_op_check #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_check (
        .op      (op),
        .count   (count_q),
        .legal   (legal),
        .set_ovf (set_ovf),
        .set_unf (set_unf),
        .delta   (delta)
    );

    // Indices are only meaningful when the matching entry exists; users are gated.
    assign top_idx  = PW'(count_q - CW'(1));
    assign nos_idx  = PW'(count_q - CW'(2));
    assign push_idx = PW'(count_q);
    assign peek_pos = PW'(count_q - CW'(1) - CW'(peek_idx));

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q + {{(CW-1){delta[1]}}, delta[0]};
        ovf_d   = ovf_q | set_ovf;
        unf_d   = unf_q | set_unf;
        if (legal) begin
            unique case (op)
                OP_PUSH:    mem_d[push_idx] = wr_data;
                OP_REPLACE: mem_d[top_idx]  = wr_data;
                OP_REDUCE:  mem_d[nos_idx]  = wr_data;
                OP_DUP:     mem_d[push_idx] = mem_q[top_idx];
                OP_SWAP: begin
                    mem_d[top_idx] = mem_q[nos_idx];
                    mem_d[nos_idx] = mem_q[top_idx];
                end
                OP_CLRERR: begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tos       = (count_q != '0)        ? mem_q[top_idx]  : '0;
    assign nos       = (count_q >= CW'(2))    ? mem_q[nos_idx]  : '0;
    assign peek_data = (CW'(peek_idx) < count_q) ? mem_q[peek_pos] : '0;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/stack_file.md
Name: stack_file

Overview:
- Parametrised LIFO operand stack for the stack-machine datapath; next generation of the fixed 8x8 two-read/two-write register file.
- Generalised in data width and depth. Adds push/pop/dup/swap/binary-reduce operations, a depth counter, full/empty flags, sticky overflow/underflow errors and a relative peek port.
- Sits between the instruction decoder (drives op/wr_data) and the ALU (reads tos/nos, returns its result via wr_data).

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries (>=2)
- CW, $clog2(DEPTH+1), count width (derived; not overridden)
- PW, $clog2(DEPTH), peek index width (derived)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  3  operation code (stack_pkg::stack_op_e), sampled each cycle
- wr_data  in  WIDTH  value for PUSH / REPLACE / REDUCE
- peek_idx  in  PW  depth below top for peek (0 = top)
- tos  out  WIDTH  top entry; 0 when empty
- nos  out  WIDTH  second entry; 0 when count<2
- peek_data  out  WIDTH  entry peek_idx below top; 0 if peek_idx>=count
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: an op needed more room than available
- underflow  out  1  sticky: an op needed more entries than present

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asserted anytime, including mid-op): count=0, all entries=0, overflow=underflow=0. Hence tos=nos=peek_data=0, empty=1, full=0. The op in flight is discarded.
- All outputs are combinational from registered state only; no input-to-output combinational path except peek_idx->peek_data. Op result is visible on the cycle after the edge (latency 1).
- One op per cycle, no handshake; the decoder must respect empty/full.
- Ops (N = count before the edge):
  - NOP: no change.
  - PUSH: needs N<DEPTH; new top=wr_data; count+1.
  - POP: needs N>=1; count-1; popped slot is not cleared.
  - REPLACE: needs N>=1; top=wr_data; count unchanged (pop+push in one cycle).
  - REDUCE: needs N>=2; removes top two, pushes wr_data; count-1. The ALU result of tos op nos returns here.
  - DUP: needs 1<=N<DEPTH; pushes copy of tos; count+1.
  - SWAP: needs N>=2; exchanges tos and nos; count unchanged.
  - CLRERR: clears overflow and underflow; stack unchanged.
- Illegal op condition: state is unchanged (no partial update). Set overflow if the requirement failed on room (PUSH/DUP with N==DEPTH). Set underflow if it failed on entries; for DUP with N==0, underflow takes priority. The flag stays 1 until CLRERR or reset.
- CLRERR has no stack effect. A later failing op re-sets the flag on that edge.
- Undefined op codes behave as NOP.
- Boundaries:
  - PUSH at N=DEPTH-1 gives full=1.
  - POP at N=1 gives empty=1, tos=0.
  - REPLACE on a full stack is legal (no overflow).
  - REDUCE with N=2 leaves N=1.
- Storage: entry i (0=bottom) in a WIDTH x DEPTH register array. tos=mem[count-1] and nos=mem[count-2], gated to 0 when absent. No wrap-around: count saturates by rule, never modulo.

Decomposition:
- Package stack_pkg: typedef enum logic [2:0] stack_op_e {OP_NOP=0, OP_PUSH=1, OP_POP=2, OP_REPLACE=3, OP_REDUCE=4, OP_DUP=5, OP_SWAP=6, OP_CLRERR=7}.
- Optional sub-module stack_op_check: pure combinational legality/error decode from (op, count). Outputs legal, set_ovf, set_unf and delta (-1/0/+1). Keeps the main module to storage and pointer update.

Test Plan:
- Reset then PUSH 0x11, 0x22, 0x33 -> count=3, tos=0x33, nos=0x22, peek_idx=2 gives 0x11, empty=0.
- Fill to DEPTH=8 with 1..8, then PUSH 0x99 -> full=1, overflow=1, count=8, tos=0x08. CLRERR -> overflow=0, stack intact.
- Empty stack POP, then REDUCE with one entry (0x05) -> underflow=1 after POP; after REDUCE count=1, tos=0x05 unchanged.
- Stack [0x03,0x04] (tos=0x04): SWAP -> tos=0x03, nos=0x04. REDUCE wr_data=0x07 -> count=1, tos=0x07. DUP -> count=2, tos=nos=0x07.
- Full stack REPLACE wr_data=0xAA -> tos=0xAA, count=8, no error. DUP on full -> overflow=1, no change.
- Assert reset asynchronously mid-cycle with count=5 and op=PUSH -> outputs go to reset values immediately, before the next clock edge; PUSH not applied after reset release.
